// File: rtl/sdram_wb_bridge.sv
// sdram_wb_bridge: Wishbone-style SDRAM port to byte-addressed controller bridge with init sequencing.
// Optional watchdog (timeout -> forced ack + sticky err) enabled by defining SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_wb_bridge #(
    parameter int INIT_CYCLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk_p,
    input  logic        sdram_reset,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [1:0]  wb_sel,
    input  logic [20:0] wb_adr,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack,
    output logic        sdram_ready,
    output logic        err,
    output logic        ctl_init,
    output logic        ctl_we,
    output logic        ctl_rd,
    output logic [1:0]  ctl_wtbt,
    output logic [24:0] ctl_addr,
    output logic [15:0] ctl_din,
    input  logic [15:0] ctl_dout,
    input  logic        ctl_ready
);
    localparam int IW = $clog2(INIT_CYCLES + 2);

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [IW-1:0] init_cnt_q;
    logic          init_q, ready_q, ack_q, we_q, rd_q, rd_dir_q;
    logic [15:0]   dat_q, din_q;
    logic [1:0]    wtbt_q;
    logic [24:0]   addr_q;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    logic          tmo_hit;
    assign tmo_hit = (state_q == ISSUE || state_q == BUSY) && tmo_q >= TW'(TIMEOUT - 1);
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_p or posedge sdram_reset) begin
        if (sdram_reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            init_q     <= 1'b1;
            ready_q    <= 1'b0;
            ack_q      <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            rd_dir_q   <= 1'b0;
            dat_q      <= '0;
            din_q      <= '0;
            wtbt_q     <= '0;
            addr_q     <= '0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
            tmo_q <= (state_q == ISSUE || state_q == BUSY) ? tmo_q + 1'b1 : '0;
`endif
            case (state_q)
                INIT: begin
                    if (init_q) begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                        if (INIT_CYCLES == 0 || init_cnt_q >= IW'(INIT_CYCLES - 1))
                            init_q <= 1'b0;
                    end else if (ctl_ready) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (wb_stb) begin
                        addr_q   <= {3'b000, wb_adr, 1'b0};
                        din_q    <= wb_dat_i;
                        wtbt_q   <= wb_we ? wb_sel : 2'b00;
                        rd_dir_q <= !wb_we;
                        // a write with no byte enables has nothing to do at the controller
                        if (wb_we && wb_sel == 2'b00) begin
                            state_q <= DONE;
                        end else begin
                            we_q    <= wb_we;
                            rd_q    <= !wb_we;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!ctl_ready) begin
                        we_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (ctl_ready) begin
                        if (rd_dir_q)
                            dat_q <= ctl_dout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ack_q <= wb_stb;
                    if (!wb_stb)
                        state_q <= IDLE;
                end
                default: state_q <= INIT;
            endcase
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
            if (tmo_hit) begin
                we_q    <= 1'b0;
                rd_q    <= 1'b0;
                err_q   <= 1'b1;
                state_q <= DONE;
                if (rd_dir_q)
                    dat_q <= 16'hFFFF;
            end
`endif
        end
    end

    assign wb_ack      = ack_q & wb_stb;
    assign wb_dat_o    = dat_q;
    assign sdram_ready = ready_q;
    assign ctl_init    = init_q;
    assign ctl_we      = we_q;
    assign ctl_rd      = rd_q;
    assign ctl_wtbt    = wtbt_q;
    assign ctl_addr    = addr_q;
    assign ctl_din     = din_q;
endmodule

// File: tb/tb_sdram_wb_bridge.sv
// tb_sdram_wb_bridge: directed bench for sdram_wb_bridge; the initial block plays both bus master and controller.
module tb_sdram_wb_bridge;
    logic        clk_p = 1'b0;
    logic        sdram_reset = 1'b1;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [1:0]  wb_sel = 2'b00;
    logic [20:0] wb_adr = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] ctl_dout = '0;
    logic        ctl_ready = 1'b1;
    logic [15:0] wb_dat_o, ctl_din;
    logic        wb_ack, sdram_ready, err, ctl_init, ctl_we, ctl_rd;
    logic [1:0]  ctl_wtbt;
    logic [24:0] ctl_addr;

    int checks = 0;
    int passes = 0;
    int fails = 0;
    logic [15:0] exp_q[$];

    always #5 clk_p = ~clk_p;

    sdram_wb_bridge #(.INIT_CYCLES(4), .TIMEOUT(16)) dut (
        .clk_p(clk_p), .sdram_reset(sdram_reset),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
        .sdram_ready(sdram_ready), .err(err),
        .ctl_init(ctl_init), .ctl_we(ctl_we), .ctl_rd(ctl_rd), .ctl_wtbt(ctl_wtbt),
        .ctl_addr(ctl_addr), .ctl_din(ctl_din), .ctl_dout(ctl_dout), .ctl_ready(ctl_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
        else check(tag, wb_dat_o, exp_q.pop_front());
    endtask

    task automatic do_reset();
        sdram_reset = 1'b1;
        wb_stb = 1'b0;
        ctl_ready = 1'b1;
        repeat (5) @(negedge clk_p);
        check("rst_init", ctl_init, 1);
        check("rst_ack", wb_ack, 0);
        check("rst_ready", sdram_ready, 0);
        check("rst_req", {ctl_we, ctl_rd}, 0);
        check("rst_addr", ctl_addr, 0);
        check("rst_err", err, 0);
        sdram_reset = 1'b0;
        repeat (3) @(negedge clk_p);
        check("init_hi", ctl_init, 1);
        @(negedge clk_p);
        check("init_lo", ctl_init, 0);
        check("ready_early", sdram_ready, 0);
        @(negedge clk_p);
        check("sdram_ready", sdram_ready, 1);
    endtask

    // busy = edges with ctl_ready low; abort drops wb_stb while the controller is busy
    task automatic access(input logic we, input logic [1:0] sel, input logic [20:0] adr,
                          input logic [15:0] dat, input logic [15:0] dout, input int busy,
                          input logic abort);
        @(negedge clk_p);
        wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_i = dat;
        if (!we) exp_q.push_back(dout);
        @(negedge clk_p);
        if (we && sel == 2'b00) begin
            check("nosel_we", {ctl_we, ctl_rd}, 0);
            check("nosel_ack_early", wb_ack, 0);
            @(negedge clk_p);
            check("nosel_ack", wb_ack, 1);
            check("nosel_we2", ctl_we, 0);
        end else begin
            check("req_addr", ctl_addr, {3'b000, adr, 1'b0});
            check("req_we", ctl_we, we);
            check("req_rd", ctl_rd, !we);
            check("req_wtbt", ctl_wtbt, we ? sel : 2'b00);
            if (we) check("req_din", ctl_din, dat);
            ctl_ready = 1'b0;
            ctl_dout = 16'hDEAD;
            for (int i = 0; i < busy; i++) begin
                @(negedge clk_p);
                check("req_held_off", {ctl_we, ctl_rd}, 0);
                if (abort && i == 0) wb_stb = 1'b0;
            end
            ctl_ready = 1'b1;
            ctl_dout = dout;
            @(negedge clk_p);
            check("ack_early", wb_ack, 0);
            @(negedge clk_p);
            ctl_dout = 16'h0000;
            check("ack", wb_ack, !abort);
            if (!we) check_pop("rd_data");
        end
        wb_stb = 1'b0;
        #1 check("ack_fall", wb_ack, 0);
        @(negedge clk_p);
    endtask

    initial begin
        do_reset();
        access(1'b0, 2'b11, 21'h0ABCD, 16'h0000, 16'h1234, 3, 1'b0);
        access(1'b1, 2'b10, 21'h1F00F, 16'hBEEF, 16'h0000, 1, 1'b0);
        access(1'b1, 2'b00, 21'h00001, 16'h5555, 16'h0000, 0, 1'b0);
        access(1'b0, 2'b01, 21'h1FFFFF, 16'h0000, 16'hA5A5, 1, 1'b1);
        access(1'b0, 2'b11, 21'h00000, 16'h0000, 16'h0F0F, 2, 1'b0);
        access(1'b1, 2'b01, 21'h12345, 16'hC3C3, 16'h0000, 4, 1'b0);

        @(negedge clk_p);
        wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h00777;
        @(negedge clk_p);
        check("mid_rd", ctl_rd, 1);
        sdram_reset = 1'b1;
        #1;
        check("mid_rd_clr", ctl_rd, 0);
        check("mid_ack", wb_ack, 0);
        check("mid_ready", sdram_ready, 0);
        check("mid_init", ctl_init, 1);
        do_reset();
        access(1'b0, 2'b11, 21'h00777, 16'h0000, 16'h7777, 1, 1'b0);

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        begin
            bit seen = 1'b0;
            @(negedge clk_p);
            wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 2'b11; wb_adr = 21'h00042;
            exp_q.push_back(16'hFFFF);
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk_p);
                seen = wb_ack;
            end
            check("tmo_ack", seen, 1);
            check_pop("tmo_data");
            check("tmo_err", err, 1);
            wb_stb = 1'b0;
            @(negedge clk_p);
            access(1'b0, 2'b11, 21'h00043, 16'h0000, 16'h4343, 1, 1'b0);
            check("err_sticky", err, 1);
        end
`else
        check("err_tied", err, 0);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
